// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter that time-shares one combinational single-precision adder
// among NREQ requesters, returning a registered sum, flags and the owner's ID.

module fp_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        overflow,
    underflow
);
    logic        swap, x_nan, x_inf, y_inf, rnd;
    logic [31:0] x, y;
    logic [23:0] mx, my;
    logic [7:0]  d;
    logic [4:0]  dcl, lz;
    logic [55:0] wide;
    logic [26:0] mx27, my27, norm;
    logic [27:0] raw;
    logic [24:0] mant;
    logic signed [9:0] exp_n;

    always_comb begin
        sum       = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        // Order operands by magnitude so alignment only ever shifts y right.
        swap  = b[30:0] > a[30:0];
        x     = swap ? b : a;
        y     = swap ? a : b;
        x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        x_inf = x[30:0] == 31'h7F80_0000;
        y_inf = y[30:0] == 31'h7F80_0000;
        // Subnormal inputs are flushed to zero.
        mx    = {1'b1, x[22:0]};
        my    = (y[30:23] == 8'd0) ? 24'd0 : {1'b1, y[22:0]};
        d     = x[30:23] - y[30:23];
        dcl   = (d > 8'd31) ? 5'd31 : d[4:0];
        wide  = {my, 32'd0} >> dcl;
        my27  = {wide[55:30], |wide[29:0]};
        mx27  = {mx, 3'b000};
        raw   = (x[31] == y[31]) ? ({1'b0, mx27} + {1'b0, my27})
                                 : ({1'b0, mx27} - {1'b0, my27});
        exp_n = $signed({2'b00, x[30:23]});
        lz    = 5'd0;
        norm  = raw[26:0];
        if (raw[27]) begin
            norm  = {raw[27:2], raw[1] | raw[0]};
            exp_n = exp_n + 10'sd1;
        end else begin
            for (int i = 0; i < 27; i++) begin
                if (raw[i]) lz = 5'(26 - i);
            end
            norm  = raw[26:0] << lz;
            exp_n = exp_n - $signed({5'd0, lz});
        end
        // Round to nearest, ties to even, on guard/round/sticky.
        rnd  = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant = {1'b0, norm[26:3]} + {24'd0, rnd};
        if (mant[24]) exp_n = exp_n + 10'sd1;

        if (x_nan || (x_inf && y_inf && (x[31] != y[31]))) begin
            sum = 32'h7FC0_0000;
        end else if (x[30:23] == 8'hFF) begin
            sum = x;
        end else if (x[30:23] == 8'd0) begin
            sum = {x[31] & y[31], 31'd0};
        end else if (raw == 28'd0) begin
            sum = 32'd0;
        end else if (exp_n >= 10'sd255) begin
            overflow = 1'b1;
            sum      = {x[31], 8'hFF, 23'd0};
        end else if (exp_n <= 10'sd0) begin
            underflow = 1'b1;
            sum       = {x[31], 31'd0};
        end else begin
            sum = {x[31], exp_n[7:0], mant[22:0]};
        end
    end
endmodule

module fp_adder_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 3,
    parameter int CNTW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_sum,
    output logic               rsp_ovf,
    output logic               rsp_unf,
    output logic               busy,
    output logic [CNTW-1:0]    ovf_count,
    output logic [CNTW-1:0]    unf_count
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  ptr, op_id, grant;
    logic [31:0]     op_a, op_b, add_sum;
    logic            add_ovf, add_unf, any_valid;

    fp_adder u_fp_adder (
        .a         (op_a),
        .b         (op_b),
        .sum       (add_sum),
        .overflow  (add_ovf),
        .underflow (add_unf)
    );

    // Walk downwards so the requester closest to ptr is the last (winning) assignment.
    always_comb begin
        grant     = '0;
        any_valid = |req_valid;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) grant = IDW'(idx);
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = (state == IDLE) && !rst && any_valid && (grant == IDW'(gi));
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_ovf   <= 1'b0;
            rsp_unf   <= 1'b0;
            rsp_id    <= '0;
            ovf_count <= '0;
            unf_count <= '0;
        end else begin
            case (state)
                IDLE: if (any_valid) begin
                    state <= CALC;
                    op_id <= grant;
                    for (int i = 0; i < NREQ; i++) begin
                        if (grant == IDW'(i)) begin
                            op_a <= req_a[32*i +: 32];
                            op_b <= req_b[32*i +: 32];
                        end
                    end
                end
                CALC: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_sum   <= add_sum;
                    rsp_ovf   <= add_ovf;
                    rsp_unf   <= add_unf;
                    rsp_id    <= op_id;
                    if (add_ovf && (ovf_count != '1)) ovf_count <= ovf_count + 1'b1;
                    if (add_unf && (unf_count != '1)) unf_count <= unf_count + 1'b1;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    ptr       <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter: hand-computed sums, grant order,
// backpressure, flag counters (narrow CNTW so saturation is reachable) and reset.

module tb_fp_adder_arbiter;
    localparam int NREQ = 2;
    localparam int IDW  = 3;
    localparam int CNTW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [32*NREQ-1:0] req_a, req_b;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid, rsp_ready, rsp_ovf, rsp_unf, busy;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_sum;
    logic [CNTW-1:0]    ovf_count, unf_count;

    int checks   = 0;
    int failures = 0;

    fp_adder_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ovf   (rsp_ovf),
        .rsp_unf   (rsp_unf),
        .busy      (busy),
        .ovf_count (ovf_count),
        .unf_count (unf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // One full operation: wait for grant, step through CALC and RESP, optional stall.
    task automatic run_op(input string tag, input logic [1:0] v, input logic [1:0] want_ready,
                          input logic [31:0] want_sum, input int want_id,
                          input logic want_ovf, input logic want_unf,
                          input bit hold, input int stall);
        int n;
        req_valid = v;
        rsp_ready = (stall == 0);
        #1;
        n = 0;
        while (req_ready == '0 && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, ".grant"}, 32'(req_ready), 32'(want_ready));
        @(negedge clk); #1;
        if (!hold) req_valid = '0;
        check({tag, ".calc_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ".calc_busy"}, 32'(busy), 32'd1);
        @(negedge clk); #1;
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".sum"}, rsp_sum, want_sum);
        check({tag, ".id"}, 32'(rsp_id), 32'(want_id));
        check({tag, ".ovf"}, 32'(rsp_ovf), 32'(want_ovf));
        check({tag, ".unf"}, 32'(rsp_unf), 32'(want_unf));
        check({tag, ".resp_ready"}, 32'(req_ready), 32'd0);
        if (stall > 0) begin
            for (int i = 1; i < stall; i++) begin
                @(negedge clk); #1;
                check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
                check({tag, ".hold_sum"}, rsp_sum, want_sum);
                check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(negedge clk); #1;
        check({tag, ".done"}, 32'(rsp_valid), 32'd0);
        $display("op %s id=%0d sum=%h ovf=%0b unf=%0b", tag, want_id, want_sum, want_ovf, want_unf);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        @(negedge clk);
        @(negedge clk); #1;
        check("rst.valid", 32'(rsp_valid), 32'd0);
        check("rst.sum", rsp_sum, 32'd0);
        check("rst.id", 32'(rsp_id), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.ready", 32'(req_ready), 32'd0);
        check("rst.cnt", 32'({ovf_count, unf_count}), 32'd0);
        req_valid = '0;
        rst       = 1'b0;

        // Single requester: 1.0 + 0.5
        req_a = {32'h0, 32'h3F80_0000};
        req_b = {32'h0, 32'h3F00_0000};
        run_op("t1", 2'b01, 2'b01, 32'h3FC0_0000, 0, 1'b0, 1'b0, 1'b0, 0);

        // Both valid after reset: req0 first, then req1
        do_reset();
        req_a = {32'h3F80_0000, 32'hBE80_0000};
        req_b = {32'hBF00_0000, 32'hBE00_0000};
        run_op("t2a", 2'b11, 2'b01, 32'hBEC0_0000, 0, 1'b0, 1'b0, 1'b1, 0);
        run_op("t2b", 2'b11, 2'b10, 32'h3F00_0000, 1, 1'b0, 1'b0, 1'b0, 0);

        // Fairness: continuous valids alternate, starting from req0 since ptr wrapped
        req_a = {32'h3F80_0000, 32'h3F80_0000};
        req_b = {32'hBF00_0000, 32'h3F00_0000};
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0)
                run_op($sformatf("t4_%0d", k), 2'b11, 2'b01, 32'h3FC0_0000, 0, 1'b0, 1'b0, k != 5, 0);
            else
                run_op($sformatf("t4_%0d", k), 2'b11, 2'b10, 32'h3F00_0000, 1, 1'b0, 1'b0, k != 5, 0);
        end

        // Backpressure on requester 1
        run_op("t3", 2'b10, 2'b10, 32'h3F00_0000, 1, 1'b0, 1'b0, 1'b0, 5);

        // Overflow: max+max -> +Inf, counter saturates at 3
        req_a = {32'h0, 32'h7F7F_FFFF};
        req_b = {32'h0, 32'h7F7F_FFFF};
        for (int k = 0; k < 4; k++) begin
            run_op($sformatf("t5_ovf%0d", k), 2'b01, 2'b01, 32'h7F80_0000, 0, 1'b1, 1'b0, 1'b0, 0);
            check($sformatf("t5.ovf_count%0d", k), 32'(ovf_count), (k < 3) ? 32'(k + 1) : 32'd3);
        end
        check("t5.unf_count0", 32'(unf_count), 32'd0);

        // Underflow: tiny difference of two smallest normals flushes to +0
        req_a = {32'h0, 32'h0080_0001};
        req_b = {32'h0, 32'h8080_0000};
        run_op("t5_unf", 2'b01, 2'b01, 32'h0000_0000, 0, 1'b0, 1'b1, 1'b0, 0);
        check("t5.unf_count1", 32'(unf_count), 32'd1);

        // NaN and Inf pass through without flags
        req_a = {32'h0, 32'h7FC0_0000};
        req_b = {32'h0, 32'h3F80_0000};
        run_op("t5_nan", 2'b01, 2'b01, 32'h7FC0_0000, 0, 1'b0, 1'b0, 1'b0, 0);
        req_a = {32'h0, 32'h7F80_0000};
        req_b = {32'h0, 32'hBF80_0000};
        run_op("t5_inf", 2'b01, 2'b01, 32'h7F80_0000, 0, 1'b0, 1'b0, 1'b0, 0);
        check("t5.ovf_count_final", 32'(ovf_count), 32'd3);

        // Reset in CALC: ptr is 1 here, so req1 is granted and then dropped
        req_a = {32'h3F80_0000, 32'h3F80_0000};
        req_b = {32'hBF00_0000, 32'h3F00_0000};
        req_valid = 2'b11;
        #1;
        check("t6.grant", 32'(req_ready), 32'd2);
        @(negedge clk); #1;
        req_valid = '0;
        check("t6.calc_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        check("t6.rst_valid", 32'(rsp_valid), 32'd0);
        check("t6.rst_busy", 32'(busy), 32'd0);
        check("t6.rst_cnt", 32'({ovf_count, unf_count}), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("t6.no_rsp", 32'(rsp_valid), 32'd0);
        run_op("t6_after", 2'b11, 2'b01, 32'h3FC0_0000, 0, 1'b0, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
